// File: rtl/n2_ifu_iq_if.sv
// n2_ifu_iq_if: decode-side queue view, redirect and instruction memory bus of the fetch unit
interface n2_ifu_iq_if;
    logic [2:0]  iq_rd_ptr_i;
    logic [2:0]  iq_prefetch_ptr_o;
    logic        instr_ready_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        fetch_busy_o;
    modport master (
        input  iq_rd_ptr_i, redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output iq_prefetch_ptr_o, instr_ready_o, instr_rdata_o, instr_pc_o, imem_req_o, imem_addr_o,
               fetch_busy_o
    );
    modport slave (
        output iq_rd_ptr_i, redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  iq_prefetch_ptr_o, instr_ready_o, instr_rdata_o, instr_pc_o, imem_req_o, imem_addr_o,
               fetch_busy_o
    );
endinterface

// File: rtl/n2_ifu_iq.sv
// n2_ifu_iq: sequential instruction fetch feeding an 8-slot (7 usable) instruction queue
module n2_ifu_iq #(
    parameter logic [31:0] PROGADDR_RESET  = 32'h0,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic        clk,
    input logic        reset,
    n2_ifu_iq_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);
    state_t      state;
    logic [2:0]  wr, occ, outstanding, discard, new_discard;
    logic [31:0] fetch_pc;
    logic [31:0] slot_data [8];
    logic [31:0] slot_pc [8];
    // PC FIFO storage covers the largest legal MAX_OUTSTANDING; pointers wrap mod 4
    logic [31:0] pc_fifo [4];
    logic [1:0]  pf_head, pf_tail;
    logic        issue, rv, keep;
    assign occ                   = wr - bus.iq_rd_ptr_i;
    assign bus.imem_req_o        = state == RUN && !bus.redirect_i &&
                                   ({1'b0, occ} + {1'b0, outstanding} < 4'd7) && outstanding < MAX_OUT;
    assign bus.imem_addr_o       = {fetch_pc[31:2], 2'b00};
    assign issue                 = bus.imem_req_o && bus.imem_gnt_i;
    assign rv                    = bus.imem_rvalid_i;
    assign keep                  = rv && discard == 3'd0 && !bus.redirect_i;
    assign new_discard           = discard + outstanding - {2'b00, rv};
    assign bus.iq_prefetch_ptr_o = wr;
    assign bus.instr_ready_o     = wr != bus.iq_rd_ptr_i;
    assign bus.instr_rdata_o     = slot_data[bus.iq_rd_ptr_i];
    assign bus.instr_pc_o        = slot_pc[bus.iq_rd_ptr_i];
    assign bus.fetch_busy_o      = outstanding != 3'd0 || discard != 3'd0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            wr          <= 3'd0;
            fetch_pc    <= PROGADDR_RESET;
            outstanding <= 3'd0;
            discard     <= 3'd0;
            pf_head     <= 2'd0;
            pf_tail     <= 2'd0;
        end else begin
            if (rv) pf_head <= pf_head + 2'd1;
            if (issue) pf_tail <= pf_tail + 2'd1;
            if (bus.redirect_i) begin
                // in-flight requests become discards; the response of this cycle is already consumed
                wr          <= bus.iq_rd_ptr_i;
                fetch_pc    <= bus.redirect_pc_i;
                discard     <= new_discard;
                outstanding <= 3'd0;
                state       <= new_discard != 3'd0 ? FLUSH : RUN;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (keep) wr <= wr + 3'd1;
                if (rv && discard != 3'd0) discard <= discard - 3'd1;
                outstanding <= outstanding + {2'b00, issue} - {2'b00, keep};
                state       <= (state == FLUSH && discard - {2'b00, rv} != 3'd0) ? FLUSH : RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (issue) pc_fifo[pf_tail] <= bus.imem_addr_o;
        if (keep) begin
            slot_data[wr] <= bus.imem_rdata_i;
            slot_pc[wr]   <= pc_fifo[pf_head];
        end
    end
endmodule

// File: tb/tb_n2_ifu_iq.sv
// tb_n2_ifu_iq: random memory/decode/redirect traffic against a program-order scoreboard
module tb_n2_ifu_iq;
    localparam logic [31:0] PROG = 32'h0;
    localparam int MAX = 2;
    typedef struct { logic [31:0] addr; bit stale; int cyc; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    logic clk = 0, reset = 1;
    n2_ifu_iq_if bus();
    n2_ifu_iq #(.PROGADDR_RESET(PROG), .MAX_OUTSTANDING(MAX)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    mreq_t mq[$];
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int p_gnt, p_rv, p_take, p_redir;
    bit boot, take, took, fixed_en, last_req;
    logic [2:0] rd, last_ptr;
    logic [31:0] exp_addr, fixed_pc, last_addr;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        int n_stale, n_live;
        bit redir, exp_req;
        mreq_t m;
        @(negedge clk);
        if (took) rd++;
        bus.iq_rd_ptr_i = rd;
        n_stale = 0;
        n_live = 0;
        foreach (mq[i]) if (mq[i].stale) n_stale++; else n_live++;
        check("busy", 32'(bus.fetch_busy_o), 32'(mq.size() != 0));
        redir = $urandom_range(99) < p_redir;
        bus.redirect_i = redir;
        bus.redirect_pc_i = fixed_en ? fixed_pc : $urandom;
        bus.imem_gnt_i = $urandom_range(99) < p_gnt;
        take = $urandom_range(99) < p_take;
        if (mq.size() != 0 && mq[0].cyc < cyc && $urandom_range(99) < p_rv) begin
            m = mq.pop_front();
            bus.imem_rvalid_i = 1;
            bus.imem_rdata_i = mw(m.addr);
        end else begin
            bus.imem_rvalid_i = 0;
            bus.imem_rdata_i = $urandom;
        end
        #1;
        exp_req = !boot && !redir && n_stale == 0 && sb.size() < 7 && n_live < MAX;
        check("req", 32'(bus.imem_req_o), 32'(exp_req));
        last_req = bus.imem_req_o;
        last_addr = bus.imem_addr_o;
        last_ptr = bus.iq_prefetch_ptr_o;
        if (bus.imem_req_o) check("addr", bus.imem_addr_o, exp_addr);
        if (bus.imem_req_o && bus.imem_gnt_i) begin
            mq.push_back('{addr: exp_addr, stale: 1'b0, cyc: cyc});
            sb.push_back('{pc: exp_addr, data: mw(exp_addr)});
            exp_addr += 32'd4;
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1;
            sb.delete();
            exp_addr = {bus.redirect_pc_i[31:2], 2'b00};
        end
        took = bus.instr_ready_o && take && !redir;
        @(posedge clk);
        cyc++;
        boot = 0;
    endtask

    task automatic do_reset();
        #3 reset = 1;
        bus.imem_rvalid_i = 0;
        bus.redirect_i = 0;
        bus.imem_gnt_i = 0;
        rd = 0;
        bus.iq_rd_ptr_i = 0;
        take = 0;
        took = 0;
        #1;
        check("rst_req", 32'(bus.imem_req_o), 0);
        check("rst_ptr", 32'(bus.iq_prefetch_ptr_o), 0);
        check("rst_busy", 32'(bus.fetch_busy_o), 0);
        check("rst_ready", 32'(bus.instr_ready_o), 0);
        mq.delete();
        sb.delete();
        exp_addr = PROG;
        @(posedge clk);
        #1 reset = 0;
        boot = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && bus.instr_ready_o && take && !bus.redirect_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dec_unexpected: got pc %h expected no word", bus.instr_pc_o);
            end else begin
                e = sb.pop_front();
                check("dec_pc", bus.instr_pc_o, e.pc);
                check("dec_data", bus.instr_rdata_o, e.data);
            end
        end
    end

    initial begin
        fixed_en = 1;
        fixed_pc = 0;
        bus.redirect_pc_i = 0;
        bus.imem_rdata_i = 0;
        do_reset();
        p_gnt = 0; p_rv = 100; p_take = 0; p_redir = 0;
        repeat (6) cycle();
        check("hold_req", 32'(last_req), 1);
        check("hold_addr", last_addr, PROG);
        p_gnt = 100;
        repeat (20) cycle();
        #1;
        check("fill_ptr", 32'(bus.iq_prefetch_ptr_o), 7);
        check("fill_ready", 32'(bus.instr_ready_o), 1);
        check("fill_data", bus.instr_rdata_o, mw(PROG));
        check("fill_pc", bus.instr_pc_o, PROG);
        fixed_pc = 32'h202; p_redir = 100;
        cycle();
        p_redir = 0;
        cycle();
        check("r202_req", 32'(last_req), 1);
        check("r202_addr", last_addr, 32'h200);
        check("r202_ptr", 32'(last_ptr), 32'(rd));
        p_take = 100;
        repeat (6) cycle();
        p_take = 0; p_rv = 0;
        repeat (3) cycle();
        fixed_pc = 32'h100; p_redir = 100;
        cycle();
        p_redir = 0; p_rv = 100;
        cycle();
        check("r100_ptr", 32'(last_ptr), 32'(rd));
        repeat (10) cycle();
        p_take = 100;
        repeat (5) cycle();
        fixed_en = 0; p_gnt = 70; p_rv = 60; p_take = 60; p_redir = 3;
        repeat (3000) cycle();
        p_redir = 0; p_gnt = 100;
        repeat (5) cycle();
        do_reset();
        cycle();
        cycle();
        check("post_rst_req", 32'(last_req), 1);
        check("post_rst_addr", last_addr, PROG);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
